traffic_light_ctrl: RTL and testbench

- Parametrised two-approach intersection controller (north-south / east-west). Next generation of the single-approach cycling light.
- Per-phase tick durations, all-red clearance, sensor-actuated green extension, latched pedestrian request with a dedicated walk phase, and a flashing-yellow fault/night mode.
- Timing advances on an external prescaler strobe, tick_en. Sits under the intersection top level, between the tick prescaler and the lamp drivers.

---
 rtl/traffic_light_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl.sv
// Two-approach (NS/EW) traffic light controller: clearance, green extension, ped walk, flash mode.
// Lamps are a pure decode of registered state; timing is paced by tick_en and there is no backpressure.
module traffic_light_ctrl #(
    parameter int TIMER_W      = 8,
    parameter int GREEN_TICKS  = 200,
    parameter int YELLOW_TICKS = 40,
    parameter int CLEAR_TICKS  = 10,
    parameter int WALK_TICKS   = 60,
    parameter int EXT_TICKS    = 50,
    parameter int MAX_EXT      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_en,
    input  logic       sensor_ns,
    input  logic       sensor_ew,
    input  logic       ped_req,
    input  logic       flash,
    output logic [2:0] ns_lamp,
    output logic [2:0] ew_lamp,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] state
);

    localparam logic [2:0] S_NS_G  = 3'd0;
    localparam logic [2:0] S_NS_Y  = 3'd1;
    localparam logic [2:0] S_AR1   = 3'd2;
    localparam logic [2:0] S_EW_G  = 3'd3;
    localparam logic [2:0] S_EW_Y  = 3'd4;
    localparam logic [2:0] S_AR2   = 3'd5;
    localparam logic [2:0] S_PED   = 3'd6;
    localparam logic [2:0] S_FLASH = 3'd7;

    localparam int EXT_W = (MAX_EXT < 1) ? 1 : $clog2(MAX_EXT + 1);

    localparam logic [TIMER_W-1:0] GREEN_LAST  = TIMER_W'(GREEN_TICKS - 1);
    localparam logic [TIMER_W-1:0] YELLOW_LAST = TIMER_W'(YELLOW_TICKS - 1);
    localparam logic [TIMER_W-1:0] CLEAR_LAST  = TIMER_W'(CLEAR_TICKS - 1);
    localparam logic [TIMER_W-1:0] WALK_LAST   = TIMER_W'(WALK_TICKS - 1);
    localparam logic [TIMER_W-1:0] EXT_RELOAD  = TIMER_W'(GREEN_TICKS - EXT_TICKS);
    localparam logic [EXT_W-1:0]   EXT_LIMIT   = EXT_W'(MAX_EXT);

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    logic [2:0]         state_q,       state_d;
    logic [TIMER_W-1:0] timer_q,       timer_d;
    logic [EXT_W-1:0]   ext_cnt_q,     ext_cnt_d;
    logic               ped_pending_q, ped_pending_d;
    logic               blink_q,       blink_d;
    logic               next_ew_q,     next_ew_d;

    logic [TIMER_W-1:0] phase_last;
    logic               at_last;
    logic               ext_ok_ns;
    logic               ext_ok_ew;
    logic               green_entry;
    logic               ped_entry;

    // Final timer value of the current phase; expiry is the tick that lands on it.
    always_comb begin
        phase_last = '0;
        case (state_q)
            S_NS_G, S_EW_G: phase_last = GREEN_LAST;
            S_NS_Y, S_EW_Y: phase_last = YELLOW_LAST;
            S_AR1,  S_AR2:  phase_last = CLEAR_LAST;
            S_PED:          phase_last = WALK_LAST;
            default:        phase_last = '0;
        endcase
    end

    assign at_last = (timer_q == phase_last);

    // Extension needs own demand, no competing demand (vehicle or pedestrian) and budget left.
    assign ext_ok_ns = sensor_ns & ~sensor_ew & ~ped_pending_q & (ext_cnt_q < EXT_LIMIT);
    assign ext_ok_ew = sensor_ew & ~sensor_ns & ~ped_pending_q & (ext_cnt_q < EXT_LIMIT);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        ext_cnt_d = ext_cnt_q;
        blink_d   = blink_q;
        next_ew_d = next_ew_q;

        if (flash && (state_q != S_FLASH)) begin
            state_d = S_FLASH;
            timer_d = '0;
            blink_d = 1'b1;
        end else if (state_q == S_FLASH) begin
            if (!flash) begin
                state_d = S_AR2;
                timer_d = '0;
            end else if (tick_en) begin
                blink_d = ~blink_q;
            end
        end else if (tick_en) begin
            if (!at_last) begin
                timer_d = timer_q + TIMER_W'(1);
            end else begin
                timer_d = '0;
                case (state_q)
                    S_NS_G: begin
                        if (ext_ok_ns) begin
                            timer_d   = EXT_RELOAD;
                            ext_cnt_d = ext_cnt_q + EXT_W'(1);
                        end else begin
                            state_d = S_NS_Y;
                        end
                    end
                    S_NS_Y: state_d = S_AR1;
                    S_AR1: begin
                        next_ew_d = 1'b1;
                        state_d   = ped_pending_q ? S_PED : S_EW_G;
                    end
                    S_EW_G: begin
                        if (ext_ok_ew) begin
                            timer_d   = EXT_RELOAD;
                            ext_cnt_d = ext_cnt_q + EXT_W'(1);
                        end else begin
                            state_d = S_EW_Y;
                        end
                    end
                    S_EW_Y: state_d = S_AR2;
                    S_AR2: begin
                        next_ew_d = 1'b0;
                        state_d   = ped_pending_q ? S_PED : S_NS_G;
                    end
                    S_PED:   state_d = next_ew_q ? S_EW_G : S_NS_G;
                    default: state_d = S_AR2;
                endcase
            end
        end
    end

    assign green_entry = (state_d != state_q) && ((state_d == S_NS_G) || (state_d == S_EW_G));
    assign ped_entry   = (state_d == S_PED) && (state_q != S_PED);

    // Serving the walk consumes the request, but a press in that same clk is kept for the next cycle.
    always_comb begin
        ped_pending_d = ped_pending_q | ped_req;
        if (ped_entry) begin
            ped_pending_d = ped_req;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_AR2;
            timer_q       <= '0;
            ext_cnt_q     <= '0;
            ped_pending_q <= 1'b0;
            blink_q       <= 1'b1;
            next_ew_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            ext_cnt_q     <= green_entry ? '0 : ext_cnt_d;
            ped_pending_q <= ped_pending_d;
            blink_q       <= blink_d;
            next_ew_q     <= next_ew_d;
        end
    end

    always_comb begin
        ns_lamp = LAMP_RED;
        ew_lamp = LAMP_RED;
        walk    = 1'b0;
        case (state_q)
            S_NS_G:  ns_lamp = LAMP_GREEN;
            S_NS_Y:  ns_lamp = LAMP_YELLOW;
            S_EW_G:  ew_lamp = LAMP_GREEN;
            S_EW_Y:  ew_lamp = LAMP_YELLOW;
            S_PED:   walk    = 1'b1;
            S_FLASH: begin
                ns_lamp = {1'b0, blink_q, 1'b0};
                ew_lamp = {1'b0, blink_q, 1'b0};
            end
            default: begin
                ns_lamp = LAMP_RED;
                ew_lamp = LAMP_RED;
            end
        endcase
    end

    assign state       = state_q;
    assign ped_pending = ped_pending_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: vector table, hand-written corner sequences, randomized run vs. reference model.
module tb_traffic_light_ctrl;

    localparam int G  = 4;
    localparam int Y  = 2;
    localparam int C  = 1;
    localparam int W  = 3;
    localparam int E  = 2;
    localparam int MX = 1;

    logic       clk;
    logic       reset, tick_en, sensor_ns, sensor_ew, ped_req, flash;
    logic [2:0] ns_lamp, ew_lamp, state;
    logic       walk, ped_pending;

    int total = 0;
    int bad   = 0;

    traffic_light_ctrl #(
        .TIMER_W(8), .GREEN_TICKS(G), .YELLOW_TICKS(Y), .CLEAR_TICKS(C),
        .WALK_TICKS(W), .EXT_TICKS(E), .MAX_EXT(MX)
    ) dut (
        .clk(clk), .reset(reset), .tick_en(tick_en), .sensor_ns(sensor_ns),
        .sensor_ew(sensor_ew), .ped_req(ped_req), .flash(flash),
        .ns_lamp(ns_lamp), .ew_lamp(ew_lamp), .walk(walk),
        .ped_pending(ped_pending), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, tk, sns, sew, ped, fl;
        logic [2:0] st, ns, ew;
        logic       wk, pp;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mkv(input logic r, t, a, b, p, f,
                                 input logic [2:0] st, ns, ew, input logic wk, pp);
        vec_t v;
        v.rst = r; v.tk = t; v.sns = a; v.sew = b; v.ped = p; v.fl = f;
        v.st = st; v.ns = ns; v.ew = ew; v.wk = wk; v.pp = pp;
        return v;
    endfunction

    function automatic logic [10:0] cur();
        return {state, ns_lamp, ew_lamp, walk, ped_pending};
    endfunction

    function automatic logic [10:0] ex(input logic [2:0] st, ns, ew, input logic wk, pp);
        return {st, ns, ew, wk, pp};
    endfunction

    task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got st/ns/ew/walk/ped=%b required=%b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, t, a, b, p, f);
        reset = r; tick_en = t; sensor_ns = a; sensor_ew = b; ped_req = p; flash = f;
        @(posedge clk);
        #1;
    endtask

    // Reference model: phase tracked as ticks remaining, counted down.
    int m_state, m_left, m_ext, m_ped, m_blink, m_next_ew;

    function automatic int dur(input int s);
        case (s)
            0, 3:    return G;
            1, 4:    return Y;
            2, 5:    return C;
            6:       return W;
            default: return 1;
        endcase
    endfunction

    task automatic m_go(input int s);
        m_state = s;
        m_left  = dur(s);
        if (s == 0 || s == 3) m_ext = 0;
    endtask

    task automatic model_step(input logic r, t, a, b, p, f);
        int ped_new;
        int own, opp;
        if (r) begin
            m_state = 5; m_left = C; m_ext = 0; m_ped = 0; m_blink = 1; m_next_ew = 0;
            return;
        end
        ped_new = (m_ped != 0 || p) ? 1 : 0;
        if (f && m_state != 7) begin
            m_state = 7; m_blink = 1;
        end else if (m_state == 7) begin
            if (!f) begin
                m_state = 5; m_left = C;
            end else if (t) begin
                m_blink = 1 - m_blink;
            end
        end else if (t) begin
            if (m_left > 1) begin
                m_left--;
            end else begin
                own = (m_state == 0) ? int'(a) : int'(b);
                opp = (m_state == 0) ? int'(b) : int'(a);
                case (m_state)
                    0, 3: begin
                        if (own == 1 && opp == 0 && m_ped == 0 && m_ext < MX) begin
                            m_left = E;
                            m_ext++;
                        end else begin
                            m_go(m_state + 1);
                        end
                    end
                    1: m_go(2);
                    4: m_go(5);
                    2: begin m_next_ew = 1; m_go(m_ped != 0 ? 6 : 3); end
                    5: begin m_next_ew = 0; m_go(m_ped != 0 ? 6 : 0); end
                    6: m_go(m_next_ew != 0 ? 3 : 0);
                    default: m_go(5);
                endcase
                if (m_state == 6) ped_new = p ? 1 : 0;
            end
        end
        m_ped = ped_new;
    endtask

    function automatic logic [10:0] model_out();
        logic [2:0] n, e, st;
        logic       w;
        n = 3'b100; e = 3'b100; w = 1'b0;
        st = 3'(m_state);
        case (m_state)
            0: n = 3'b001;
            1: n = 3'b010;
            3: e = 3'b001;
            4: e = 3'b010;
            6: w = 1'b1;
            7: begin n = {1'b0, m_blink[0], 1'b0}; e = n; end
            default: ;
        endcase
        return {st, n, e, w, m_ped[0]};
    endfunction

    int ext_seq[23];

    initial begin
        logic s_ns, s_ew, s_fl, r, t, p;
        reset = 1'b1; tick_en = 1'b0; sensor_ns = 1'b0; sensor_ew = 1'b0; ped_req = 1'b0; flash = 1'b0;

        // Free-run from reset with all sensors idle, then a no-tick hold and a tickless ped latch.
        vecs[0]  = mkv(1,0,0,0,0,0, 3'd5, 3'b100, 3'b100, 0, 0);
        vecs[1]  = mkv(0,1,0,0,0,0, 3'd0, 3'b001, 3'b100, 0, 0);
        vecs[2]  = mkv(0,1,0,0,0,0, 3'd0, 3'b001, 3'b100, 0, 0);
        vecs[3]  = mkv(0,1,0,0,0,0, 3'd0, 3'b001, 3'b100, 0, 0);
        vecs[4]  = mkv(0,1,0,0,0,0, 3'd0, 3'b001, 3'b100, 0, 0);
        vecs[5]  = mkv(0,1,0,0,0,0, 3'd1, 3'b010, 3'b100, 0, 0);
        vecs[6]  = mkv(0,1,0,0,0,0, 3'd1, 3'b010, 3'b100, 0, 0);
        vecs[7]  = mkv(0,1,0,0,0,0, 3'd2, 3'b100, 3'b100, 0, 0);
        vecs[8]  = mkv(0,1,0,0,0,0, 3'd3, 3'b100, 3'b001, 0, 0);
        vecs[9]  = mkv(0,1,0,0,0,0, 3'd3, 3'b100, 3'b001, 0, 0);
        vecs[10] = mkv(0,1,0,0,0,0, 3'd3, 3'b100, 3'b001, 0, 0);
        vecs[11] = mkv(0,1,0,0,0,0, 3'd3, 3'b100, 3'b001, 0, 0);
        vecs[12] = mkv(0,1,0,0,0,0, 3'd4, 3'b100, 3'b010, 0, 0);
        vecs[13] = mkv(0,1,0,0,0,0, 3'd4, 3'b100, 3'b010, 0, 0);
        vecs[14] = mkv(0,1,0,0,0,0, 3'd5, 3'b100, 3'b100, 0, 0);
        vecs[15] = mkv(0,1,0,0,0,0, 3'd0, 3'b001, 3'b100, 0, 0);
        vecs[16] = mkv(0,0,0,0,0,0, 3'd0, 3'b001, 3'b100, 0, 0);
        vecs[17] = mkv(0,1,0,0,0,0, 3'd0, 3'b001, 3'b100, 0, 0);
        vecs[18] = mkv(0,0,0,0,1,0, 3'd0, 3'b001, 3'b100, 0, 1);

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].rst, vecs[i].tk, vecs[i].sns, vecs[i].sew, vecs[i].ped, vecs[i].fl);
            chk($sformatf("table[%0d]", i), cur(),
                ex(vecs[i].st, vecs[i].ns, vecs[i].ew, vecs[i].wk, vecs[i].pp));
        end

        // One NS extension (6 ticks of green), then a fresh budget on the next NS green.
        ext_seq = '{0,0,0,0,0,0, 1,1, 2, 3,3,3,3, 4,4, 5, 0,0,0,0,0,0, 1};
        drive(1,0,0,0,0,0);
        for (int i = 0; i < 23; i++) begin
            drive(0,1,1,0,0,0);
            chk($sformatf("ext_state[%0d]", i + 1), {8'd0, state}, {8'd0, 3'(ext_seq[i])});
        end

        // Competing demand blocks extension.
        drive(1,0,0,0,0,0);
        for (int i = 1; i <= 5; i++) drive(0,1,1,1,0,0);
        chk("both_sensors_no_ext", cur(), ex(3'd1, 3'b010, 3'b100, 0, 0));

        // Pending pedestrian blocks extension.
        drive(1,0,0,0,0,0);
        drive(0,1,1,0,0,0);
        drive(0,1,1,0,1,0);
        for (int i = 3; i <= 5; i++) drive(0,1,1,0,0,0);
        chk("ped_blocks_ext", cur(), ex(3'd1, 3'b010, 3'b100, 0, 1));

        // Ped pulse during NS_G: walk after AR1 for 3 ticks, then EW_G.
        drive(1,0,0,0,0,0);
        drive(0,1,0,0,0,0);
        drive(0,1,0,0,1,0);
        chk("ped_latched", cur(), ex(3'd0, 3'b001, 3'b100, 0, 1));
        for (int i = 3; i <= 7; i++) drive(0,1,0,0,0,0);
        chk("ped_at_ar1", cur(), ex(3'd2, 3'b100, 3'b100, 0, 1));
        drive(0,1,0,0,0,0);
        chk("walk_entry", cur(), ex(3'd6, 3'b100, 3'b100, 1, 0));
        drive(0,1,0,0,0,0);
        drive(0,1,0,0,0,0);
        chk("walk_last", cur(), ex(3'd6, 3'b100, 3'b100, 1, 0));
        drive(0,1,0,0,0,0);
        chk("walk_to_ew_g", cur(), ex(3'd3, 3'b100, 3'b001, 0, 0));

        // Ped held high through walk entry: request survives the clear.
        drive(1,0,0,0,0,0);
        for (int i = 1; i <= 8; i++) drive(0,1,0,0,1,0);
        chk("ped_set_wins_clear", cur(), ex(3'd6, 3'b100, 3'b100, 1, 1));
        for (int i = 9; i <= 11; i++) drive(0,1,0,0,0,0);
        chk("walk_to_ew_g_pending", cur(), ex(3'd3, 3'b100, 3'b001, 0, 1));

        // Flash entered mid-EW_G without a tick, blink per tick, exit via AR2.
        drive(1,0,0,0,0,0);
        for (int i = 1; i <= 8; i++) drive(0,1,0,0,0,0);
        drive(0,0,0,0,0,1);
        chk("flash_entry", cur(), ex(3'd7, 3'b010, 3'b010, 0, 0));
        drive(0,1,0,0,0,1);
        chk("flash_blink_off", cur(), ex(3'd7, 3'b000, 3'b000, 0, 0));
        drive(0,1,0,0,0,1);
        chk("flash_blink_on", cur(), ex(3'd7, 3'b010, 3'b010, 0, 0));
        drive(0,0,0,0,0,1);
        chk("flash_hold_no_tick", cur(), ex(3'd7, 3'b010, 3'b010, 0, 0));
        drive(0,1,0,0,0,1);
        chk("flash_blink_off2", cur(), ex(3'd7, 3'b000, 3'b000, 0, 0));
        drive(0,1,0,0,0,0);
        chk("flash_exit_ar2", cur(), ex(3'd5, 3'b100, 3'b100, 0, 0));
        drive(0,1,0,0,0,0);
        chk("flash_exit_ns_g", cur(), ex(3'd0, 3'b001, 3'b100, 0, 0));

        // Reset mid-walk with tick_en low and a fresh request pending.
        drive(1,0,0,0,0,0);
        drive(0,1,0,0,0,0);
        drive(0,1,0,0,1,0);
        for (int i = 3; i <= 8; i++) drive(0,1,0,0,0,0);
        drive(0,1,0,0,1,0);
        chk("walk_relatch", cur(), ex(3'd6, 3'b100, 3'b100, 1, 1));
        drive(1,0,0,0,0,0);
        chk("reset_mid_walk", cur(), ex(3'd5, 3'b100, 3'b100, 0, 0));

        // Randomized run against the reference model.
        s_ns = 1'b0; s_ew = 1'b0; s_fl = 1'b0;
        drive(1,0,0,0,0,0);
        model_step(1,0,0,0,0,0);
        chk("rand_reset", cur(), model_out());
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) s_ns = ~s_ns;
            if ($urandom_range(0, 7) == 0) s_ew = ~s_ew;
            if ($urandom_range(0, 99) == 0) s_fl = ~s_fl;
            r = ($urandom_range(0, 149) == 0);
            t = ($urandom_range(0, 3) != 0);
            p = ($urandom_range(0, 19) == 0);
            drive(r, t, s_ns, s_ew, p, s_fl);
            model_step(r, t, s_ns, s_ew, p, s_fl);
            chk($sformatf("rand[%0d]", i), cur(), model_out());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
